// File: rtl/transmitter_ctrl.sv
// Sequencer for the UART TX shift datapath: 1-entry holding register, baud timer,
// and load/next/frame_done strobes; a queued byte reloads on frame_done with no idle gap.
module transmitter_ctrl #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       load,
  output logic       next,
  output logic [7:0] x,
  input  logic       msb,
  output logic       busy,
  output logic       frame_done
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] T_END = TW'(CLK_DIV - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic           hold_full;
  logic [7:0]     hold_data;
  logic           bit_end;

  // Handshake: a byte moves on din_valid & din_ready; din_ready is simply the
  // registered "holding register empty" flag, so it can never fall combinationally.
  assign din_ready = !hold_full;
  assign x         = hold_data;
  assign busy      = (state == SEND) || hold_full;

  assign bit_end = (state == SEND) && (timer == T_END);

  always_comb begin
    load       = ((state == IDLE) && hold_full) || (bit_end && msb && hold_full);
    next       = bit_end && !msb;
    frame_done = bit_end && msb;
  end

  // Holding register: a pop (load) always wins; pushes only happen while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (din_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (hold_full) state <= SEND;
        end
        SEND: begin
          if (bit_end) begin
            timer <= '0;
            if (msb && !hold_full) state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
